// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver with scan-code-set-2 to ASCII translation
// and a two-register CPU read port.
//   sys_clock  : system clock, all state on rising edge
//   reset_n    : asynchronous active-low reset
//   cpu_clken  : CPU clock enable, qualifies r_en
//   ps2_clk    : PS/2 clock (asynchronous, idle high)
//   ps2_data   : PS/2 data  (asynchronous, idle high)
//   address    : 0 = KBD data register, 1 = KBDCR status
//   r_en       : CPU read strobe
//   dout       : read data (combinational mux)
//   key_ready  : character pending
//   clr_screen : one-cycle clear-screen request (F1)
//   reset_key  : one-cycle system reset request (F12)
module ps2_keyboard #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       sys_clock,
    input  logic       reset_n,
    input  logic       cpu_clken,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       address,
    input  logic       r_en,
    output logic [7:0] dout,
    output logic       key_ready,
    output logic       clr_screen,
    output logic       reset_key
);

    localparam int unsigned FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic              filt_clk_q;
    logic [FILT_W-1:0] filt_cnt_q;
    logic              filt_flip_c, fall_c;

    state_e            state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shreg_q;
    logic              par_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              rx_valid_q;
    logic [7:0]        rx_code_q;

    logic [7:0]        data_q, data_d;
    logic              key_ready_q, key_ready_d;
    logic              clr_q, clr_d, rstk_q, rstk_d;
    logic              shift_q, shift_d, ext_q, ext_d, brk_q, brk_d;
    logic [7:0]        tr_c;

    // Scan code -> {valid, 7-bit ASCII}; letters are always uppercase.
    function automatic logic [7:0] translate(input logic [7:0] code, input logic sh);
        logic       v;
        logic [6:0] ch;
        v  = 1'b1;
        ch = 7'h00;
        case (code)
            8'h1C: ch = 7'h41; 8'h32: ch = 7'h42; 8'h21: ch = 7'h43; 8'h23: ch = 7'h44;
            8'h24: ch = 7'h45; 8'h2B: ch = 7'h46; 8'h34: ch = 7'h47; 8'h33: ch = 7'h48;
            8'h43: ch = 7'h49; 8'h3B: ch = 7'h4A; 8'h42: ch = 7'h4B; 8'h4B: ch = 7'h4C;
            8'h3A: ch = 7'h4D; 8'h31: ch = 7'h4E; 8'h44: ch = 7'h4F; 8'h4D: ch = 7'h50;
            8'h15: ch = 7'h51; 8'h2D: ch = 7'h52; 8'h1B: ch = 7'h53; 8'h2C: ch = 7'h54;
            8'h3C: ch = 7'h55; 8'h2A: ch = 7'h56; 8'h1D: ch = 7'h57; 8'h22: ch = 7'h58;
            8'h35: ch = 7'h59; 8'h1A: ch = 7'h5A;
            8'h16: ch = sh ? 7'h21 : 7'h31;
            8'h1E: ch = sh ? 7'h40 : 7'h32;
            8'h26: ch = sh ? 7'h23 : 7'h33;
            8'h25: ch = sh ? 7'h24 : 7'h34;
            8'h2E: ch = sh ? 7'h25 : 7'h35;
            8'h36: ch = sh ? 7'h5E : 7'h36;
            8'h3D: ch = sh ? 7'h26 : 7'h37;
            8'h3E: ch = sh ? 7'h2A : 7'h38;
            8'h46: ch = sh ? 7'h28 : 7'h39;
            8'h45: ch = sh ? 7'h29 : 7'h30;
            8'h0E: ch = sh ? 7'h7E : 7'h60;
            8'h4E: ch = sh ? 7'h5F : 7'h2D;
            8'h55: ch = sh ? 7'h2B : 7'h3D;
            8'h54: ch = sh ? 7'h7B : 7'h5B;
            8'h5B: ch = sh ? 7'h7D : 7'h5D;
            8'h5D: ch = sh ? 7'h7C : 7'h5C;
            8'h4C: ch = sh ? 7'h3A : 7'h3B;
            8'h52: ch = sh ? 7'h22 : 7'h27;
            8'h41: ch = sh ? 7'h3C : 7'h2C;
            8'h49: ch = sh ? 7'h3E : 7'h2E;
            8'h4A: ch = sh ? 7'h3F : 7'h2F;
            8'h29: ch = 7'h20;
            8'h5A: ch = 7'h0D;
            8'h66: ch = 7'h5F;
            8'h76: ch = 7'h1B;
            default: v = 1'b0;
        endcase
        return {v, ch};
    endfunction

    // Two-flop synchronizers, reset to the idle-high level.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: flip only after FILTER_LEN consecutive differing samples.
    assign filt_flip_c = (clk_s2_q != filt_clk_q) && (filt_cnt_q == FILT_W'(FILTER_LEN - 1));
    assign fall_c      = filt_flip_c & filt_clk_q;

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s2_q == filt_clk_q) begin
            filt_cnt_q <= '0;
        end else if (filt_flip_c) begin
            filt_clk_q <= ~filt_clk_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + FILT_W'(1);
        end
    end

    // Frame receiver: start, 8 data LSB first, odd parity, stop; with inter-edge timeout.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_code_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            if (fall_c) begin
                to_cnt_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg_q   <= {dat_s2_q, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= ST_STOP;
                    end
                    default: begin
                        if (dat_s2_q && (^{shreg_q, par_q})) begin
                            rx_valid_q <= 1'b1;
                            rx_code_q  <= shreg_q;
                        end
                        state_q <= ST_IDLE;
                    end
                endcase
            end else if (state_q == ST_IDLE) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                to_cnt_q <= '0;
                state_q  <= ST_IDLE;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    assign tr_c = translate(rx_code_q, shift_q);

    // Scan-code interpretation: prefix flags, shift tracking, function keys, char latch.
    always_comb begin
        data_d      = data_q;
        key_ready_d = key_ready_q;
        clr_d       = 1'b0;
        rstk_d      = 1'b0;
        shift_d     = shift_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        if (cpu_clken && r_en && !address) key_ready_d = 1'b0;
        if (rx_valid_q) begin
            if (rx_code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (rx_code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (brk_q) begin
                    if (rx_code_q == 8'h12 || rx_code_q == 8'h59) shift_d = 1'b0;
                end else if (!ext_q) begin
                    if (rx_code_q == 8'h12 || rx_code_q == 8'h59) begin
                        shift_d = 1'b1;
                    end else if (rx_code_q == 8'h05) begin
                        clr_d = 1'b1;
                    end else if (rx_code_q == 8'h07) begin
                        rstk_d = 1'b1;
                    end else if (tr_c[7]) begin
                        // A new character wins over a same-cycle clearing read.
                        data_d      = {1'b1, tr_c[6:0]};
                        key_ready_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= '0;
            key_ready_q <= 1'b0;
            clr_q       <= 1'b0;
            rstk_q      <= 1'b0;
            shift_q     <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            data_q      <= data_d;
            key_ready_q <= key_ready_d;
            clr_q       <= clr_d;
            rstk_q      <= rstk_d;
            shift_q     <= shift_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
        end
    end

    assign key_ready  = key_ready_q;
    assign clr_screen = clr_q;
    assign reset_key  = rstk_q;
    assign dout       = address ? {key_ready_q, 7'b0} : data_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
module tb_ps2_keyboard;

    localparam int unsigned FLEN = 4;
    localparam int unsigned TOUT = 200;
    localparam int unsigned H    = 20;

    logic       sys_clock = 1'b0;
    logic       reset_n   = 1'b0;
    logic       cpu_clken = 1'b0;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic       address   = 1'b0;
    logic       r_en      = 1'b0;
    logic [7:0] dout;
    logic       key_ready, clr_screen, reset_key;

    int total = 0;
    int bad   = 0;
    int clr_hits = 0;
    int rst_hits = 0;
    logic [7:0] exp_q[$];

    ps2_keyboard #(.FILTER_LEN(FLEN), .TIMEOUT(TOUT)) dut (
        .sys_clock (sys_clock),
        .reset_n   (reset_n),
        .cpu_clken (cpu_clken),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .address   (address),
        .r_en      (r_en),
        .dout      (dout),
        .key_ready (key_ready),
        .clr_screen(clr_screen),
        .reset_key (reset_key)
    );

    always #5 sys_clock = ~sys_clock;

    always @(negedge sys_clock) begin
        if (clr_screen) clr_hits++;
        if (reset_key)  rst_hits++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clock);
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        cyc(H / 2);
        if (glitch) begin
            ps2_clk = 1'b0;
            cyc(2);
            ps2_clk = 1'b1;
            cyc(H / 2 - 2);
        end else begin
            cyc(H / 2);
        end
        ps2_clk = 1'b0;
        cyc(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit glitch);
        logic [10:0] bits;
        logic        par;
        par = ~^code;
        if (bad_par) par = ~par;
        bits = {1'b1, par, code, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i], glitch && (i == 4));
        ps2_data = 1'b1;
        cyc(H);
    endtask

    task automatic send_partial(input logic [7:0] code, input int nbits);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(code[i], 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic cpu_read(input logic a);
        address   = a;
        cpu_clken = 1'b1;
        r_en      = 1'b1;
        cyc(1);
        cpu_clken = 1'b0;
        r_en      = 1'b0;
        cyc(1);
    endtask

    // No FIFO in the design: a newer character replaces the pending expectation.
    task automatic expect_char(input logic [7:0] c);
        exp_q.delete();
        exp_q.push_back(c);
    endtask

    task automatic check_char(input string tag);
        int         n;
        logic [7:0] e;
        n = 0;
        while (key_ready !== 1'b1 && n < 300) begin
            cyc(1);
            n++;
        end
        chk({tag, "_rdy"}, {7'b0, key_ready}, 8'h01);
        address = 1'b1;
        cyc(1);
        chk({tag, "_stat"}, dout, 8'h80);
        address = 1'b0;
        cyc(1);
        e = 8'h00;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, "_dout"}, dout, e);
        cpu_read(1'b0);
        chk({tag, "_clr"}, {7'b0, key_ready}, 8'h00);
    endtask

    initial begin
        int c0, r0;

        // Reset state
        cyc(3);
        address = 1'b0;
        cyc(1);
        chk("rst_dout", dout, 8'h00);
        chk("rst_kr", {7'b0, key_ready}, 8'h00);
        chk("rst_clr", {7'b0, clr_screen}, 8'h00);
        chk("rst_rk", {7'b0, reset_key}, 8'h00);
        address = 1'b1;
        cyc(1);
        chk("rst_stat", dout, 8'h00);
        reset_n = 1'b1;
        cyc(10);

        // 'A'
        send_frame(8'h1C, 1'b0, 1'b0);
        expect_char(8'hC1);
        check_char("A");

        // Shift + '1' gives '!', then unshifted '1'
        send_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'h16, 1'b0, 1'b0);
        expect_char(8'hA1);
        check_char("bang");
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h16, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);
        chk("brk_none", {7'b0, key_ready}, 8'h00);
        send_frame(8'h16, 1'b0, 1'b0);
        expect_char(8'hB1);
        check_char("one");

        // Bad parity discarded, next frame fine
        send_frame(8'h1C, 1'b1, 1'b0);
        cyc(10);
        chk("par_none", {7'b0, key_ready}, 8'h00);
        send_frame(8'h32, 1'b0, 1'b0);
        expect_char(8'hC2);
        check_char("B");

        // Abandoned frame times out
        send_partial(8'h5A, 4);
        cyc(TOUT + 20);
        chk("to_none", {7'b0, key_ready}, 8'h00);
        send_frame(8'h5A, 1'b0, 1'b0);
        expect_char(8'h8D);
        check_char("enter");

        // F1 / F12 pulses
        c0 = clr_hits;
        r0 = rst_hits;
        send_frame(8'h05, 1'b0, 1'b0);
        cyc(5);
        chk("f1_clr", 8'(clr_hits - c0), 8'h01);
        chk("f1_rk", 8'(rst_hits - r0), 8'h00);
        send_frame(8'h07, 1'b0, 1'b0);
        cyc(5);
        chk("f12_rk", 8'(rst_hits - r0), 8'h01);
        chk("f12_clr", 8'(clr_hits - c0), 8'h01);
        chk("fn_kr", {7'b0, key_ready}, 8'h00);

        // Overwrite; status read has no side effect
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0);
        expect_char(8'hC2);
        cpu_read(1'b1);
        chk("stat_keep", {7'b0, key_ready}, 8'h01);
        check_char("ovw");

        // Reset mid-frame, then a frame with a short clock glitch
        send_partial(8'h29, 3);
        reset_n = 1'b0;
        cyc(3);
        address = 1'b0;
        cyc(1);
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_kr", {7'b0, key_ready}, 8'h00);
        reset_n = 1'b1;
        cyc(10);
        send_frame(8'h29, 1'b0, 1'b1);
        expect_char(8'hA0);
        check_char("space");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
